// File: rtl/sap_ram_loader.sv
// sap_ram_loader
// Program writer and read port for the SAP RAM. A session starts on
// load_start, takes 2^ADDR_WIDTH program bytes over a valid/ready handshake
// into RAM from address 0 upward, then takes one trailing two's-complement
// checksum byte. The CPU is held off the bus for the whole session.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   load_start     begin a session (honoured only in IDLE)
//   byte_valid     byte_data holds a valid byte
//   byte_data      program byte or checksum byte
//   byte_ready     loader accepts a byte this cycle (LOAD/CHECK)
//   mem_addr       CPU read address (MAR)
//   mem_data       RAM word at mem_addr, 0 while cpu_hold is high
//   cpu_hold       CPU must stall (every state except IDLE)
//   load_done      one-cycle pulse when a session completes
//   checksum_error sticky checksum mismatch flag for the last session
//   word_count     RAM words written in the current or last session
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | CPU owns the read port; waits for load_start
// LOAD  | accepting program bytes into RAM
// CHECK | accepting the checksum byte (not written to RAM)
// DONE  | load_done pulse, back to IDLE
module sap_ram_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  checksum_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_nxt;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic                  start_sess;
  logic                  wr_en;
  logic                  chk_en;
  logic                  last_addr;

  assign last_addr = (addr == {ADDR_WIDTH{1'b1}});
  assign sum_nxt   = sum + byte_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // byte_ready is a pure function of state, so byte_valid alone marks a
  // transfer inside LOAD/CHECK.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    start_sess = 1'b0;
    wr_en      = 1'b0;
    chk_en     = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (load_start) begin
          start_sess = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          wr_en = 1'b1;
          if (last_addr) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          chk_en    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr           <= '0;
      sum            <= '0;
      word_count     <= '0;
      checksum_error <= 1'b0;
    end else if (start_sess) begin
      addr           <= '0;
      sum            <= '0;
      word_count     <= '0;
      checksum_error <= 1'b0;
    end else if (wr_en) begin
      addr       <= addr + 1'b1;
      sum        <= sum_nxt;
      word_count <= word_count + 1'b1;
    end else if (chk_en) begin
      checksum_error <= |sum_nxt;
    end
  end

  // RAM survives reset so a partial load stays visible.
  always_ff @(posedge clock) begin
    if (wr_en) ram[addr] <= byte_data;
  end

  assign mem_data = cpu_hold ? '0 : ram[mem_addr];

endmodule

// File: doc/sap_ram_loader.md
# sap_ram_loader

Program writer for the SAP 16×8 RAM. It accepts a stream of program bytes over a valid/ready handshake and writes them into the RAM from address 0 upward. It then checks a trailing two's-complement checksum byte and holds the CPU off the bus while loading is in progress. The same block serves the CPU's combinational read port (MAR address in, RAM word out), so the RAM no longer needs preloading at elaboration.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: RAM word and stream byte width.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  single-cycle request to begin a load session; honoured only in IDLE.
- `byte_valid`  in  1  `byte_data` holds a valid byte.
- `byte_data`  in  DATA_WIDTH  program byte or checksum byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `mem_addr`  in  ADDR_WIDTH  CPU read address (from MAR).
- `mem_data`  out  DATA_WIDTH  RAM word at `mem_addr`; forced to 0 while `cpu_hold` = 1.
- `cpu_hold`  out  1  high in every state except IDLE; the CPU must stall.
- `load_done`  out  1  one-cycle pulse when a session completes.
- `checksum_error`  out  1  sticky mismatch flag for the last session.
- `word_count`  out  ADDR_WIDTH+1  number of RAM words written in the current or last session.

## Operation
- FSM states: IDLE, LOAD, CHECK, DONE.
  - IDLE: `load_start` = 1 → LOAD. On entry, address counter ← 0, running sum ← 0, `word_count` ← 0, `checksum_error` ← 0.
  - LOAD: on each transfer (`byte_valid` & `byte_ready`):
    - ram[addr] ← `byte_data`
    - sum ← (sum + `byte_data`) mod 2^DATA_WIDTH
    - addr ← addr + 1
    - `word_count` ← `word_count` + 1
    - Transfer at addr = 2^ADDR_WIDTH−1 → CHECK. The address counter wraps to 0 and is not used again.
  - CHECK: on a transfer, `checksum_error` ← ((sum + `byte_data`) mod 2^DATA_WIDTH ≠ 0), then → DONE. The checksum byte is never written to RAM.
  - DONE: `load_done` = 1 for this single cycle → IDLE.
- `byte_ready` = 1 in LOAD and CHECK, 0 in IDLE and DONE. It is a pure function of state.
- `load_start` outside IDLE is ignored. It does not restart, queue, or alter the session.
- `byte_valid` in IDLE/DONE is ignored: no write, no state change.
- Stalls: `byte_valid` may drop between bytes for any number of cycles; the FSM waits in place.
- Read port is combinational: `mem_data` = ram[`mem_addr`] when `cpu_hold` = 0, else 0.
- A checksum error does not invalidate RAM contents. The system decides whether to release the CPU; the loader only reports the error.

## Timing
- Reset (async assert, `reset` = 0):
  - state = IDLE, `byte_ready` = 0, `cpu_hold` = 0, `load_done` = 0
  - `checksum_error` = 0, `word_count` = 0, address counter = 0, sum = 0
  - RAM contents are not cleared by reset.
- Reset deassertion is synchronous to `clock` at the system level; the first active edge after release sees IDLE.
- Reset mid-session aborts immediately. RAM keeps the words written so far, `cpu_hold` drops asynchronously, and no `load_done` is produced.
- `load_start` sampled at edge N → `cpu_hold` = 1 and `byte_ready` = 1 from edge N.
- A byte transferred at edge N is visible on `mem_data` (for that address) once `cpu_hold` falls.
- Minimum session: 1 + 2^ADDR_WIDTH + 1 + 1 cycles (start, data, checksum, DONE).
- The checksum transfer at edge N gives DONE after N, with `load_done` high for cycle N→N+1. `checksum_error` is valid from N. `cpu_hold` falls at edge N+1.
- Arithmetic: sum and the checksum compare are modulo 2^DATA_WIDTH. `word_count` saturates naturally at 2^ADDR_WIDTH (no overflow, width ADDR_WIDTH+1).

## Test plan
- Nominal load:
  - Stimulus: `load_start`, then bytes 0F 1E 1D 2C E0 F0 00 00 00 00 00 00 06 02 08 0A, checksum A0, with `byte_valid` held high.
  - Required: `load_done` pulse 18 cycles after start, `checksum_error` = 0, `word_count` = 16, `cpu_hold` back to 0.
  - Required on the read port: `mem_addr` = 0 → 0F, 4 → E0, 15 → 0A.
- Bad checksum: same stream with checksum A1 → `checksum_error` = 1, `load_done` pulses, RAM holds the 16 data bytes. A following good session clears the flag.
- Stalled stream: `byte_valid` toggles 1/0 with random gaps → identical RAM contents and flag as the nominal case. No byte is written twice; no byte is written in a gap cycle.
- Ignored inputs:
  - `load_start` pulsed mid-LOAD → session continues unchanged.
  - `byte_valid` = 1 in IDLE → no RAM change, `byte_ready` stays 0.
- Reset mid-session: assert `reset` = 0 after 5 bytes → `cpu_hold` = 0 and state IDLE immediately. Addresses 0–4 hold the new bytes, addresses 5–15 are unchanged, no `load_done`.
- Hold masking: during LOAD, drive `mem_addr` = 0 → `mem_data` = 00. After DONE → the loaded value.
